// File: rtl/sine_dac_pkg.sv
// sine_dac_pkg: serializer state encoding and default frame geometry for sine_dac_spi.
package sine_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } dac_state_e;

  localparam int unsigned CMD_W_DEF = 8;
  localparam int unsigned DAC_W_DEF = 16;
  localparam int unsigned FRAME_W   = CMD_W_DEF + DAC_W_DEF;

  // Write-and-update command sent ahead of every sample.
  localparam logic [CMD_W_DEF-1:0] CMD_DEF = 8'h30;

endpackage

// File: rtl/sine_dac_spi_sclk_divider.sv
// sclk_divider: one-cycle tick_half pulse every CLK_DIV clocks while en is high;
// the count is held at zero while disabled so every enable starts a fresh period.
module sclk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_half
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_half = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/sine_dac_spi.sv
// sine_dac_spi: 1-deep sample buffer feeding a mode-0 SPI DAC serializer ({CMD, sample MSBs}).
// Optional build macro SINE_DAC_OFFSET_BIN_EN: invert the sample MSB on load (offset binary).
module sine_dac_spi
  import sine_dac_pkg::*;
#(
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      DAC_W   = FRAME_W - CMD_W_DEF,
  parameter int unsigned      CMD_W   = CMD_W_DEF,
  parameter logic [CMD_W-1:0] CMD     = CMD_DEF,
  parameter int unsigned      CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned FRAME_LEN = CMD_W + DAC_W;
  localparam int unsigned BIT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN);

  dac_state_e           state_q, state_d;
  logic [DAC_W-1:0]     buf_q, buf_d, sample_in;
  logic                 buf_full_q, buf_full_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;
  logic                 tick_half, div_en, unload, last_bit;
  logic                 unused_lsbs;

`ifdef SINE_DAC_OFFSET_BIN_EN
  assign sample_in = {~in_data[DATA_W-1], in_data[DATA_W-2 -: DAC_W-1]};
`else
  assign sample_in = in_data[DATA_W-1 -: DAC_W];
`endif
  assign unused_lsbs = ^in_data[DATA_W-DAC_W-1:0];

  assign div_en   = (state_q != IDLE);
  assign unload   = (state_q == IDLE) && buf_full_q;
  assign last_bit = (bit_cnt_q == LAST_BIT);

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_sclk_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (div_en),
    .tick_half(tick_half)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (buf_full_q) state_d = SETUP;
      SETUP:   if (tick_half) state_d = SHIFT;
      SHIFT:   if (tick_half && sclk_q && last_bit) state_d = HOLD;
      HOLD:    if (tick_half) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sample arriving in the same cycle the buffer unloads is accepted, not an overrun.
  always_comb begin
    buf_d        = buf_q;
    buf_full_d   = buf_full_q && !unload;
    overrun_d    = overrun_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (!buf_full_q || unload) begin
        buf_d      = sample_in;
        buf_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    case (state_q)
      IDLE: if (buf_full_q) begin
        shift_d   = {CMD, buf_q};
        bit_cnt_d = '0;
        sclk_d    = 1'b0;
        cs_n_d    = 1'b0;
      end
      SHIFT: if (tick_half) begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
          if (!last_bit) bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          sclk_d = 1'b0;
          if (!last_bit) shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
        end
      end
      HOLD: if (tick_half) begin
        cs_n_d       = 1'b1;
        frame_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      overrun_q    <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      overrun_q    <= overrun_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // mosi is the shift register MSB, so it only moves on load and on sclk falling edges.
  assign mosi       = shift_q[FRAME_LEN-1];
  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign in_ready   = ~buf_full_q;
  assign busy       = div_en;

endmodule

// File: tb/tb_sine_dac_spi.sv
// tb_sine_dac_spi: table-driven, hand-written and random checks of sine_dac_spi against
// a frame-level reference model (sample acceptance, frame contents and frame timing).
module tb_sine_dac_spi;

  localparam int unsigned CMD_W     = 8;
  localparam int unsigned DAC_W     = 16;
  localparam int unsigned CLK_DIV   = 4;
  localparam logic [7:0]  CMD       = 8'h30;
  localparam int          NBITS     = CMD_W + DAC_W;
  localparam int          FRAME_CYC = (NBITS + 1) * 2 * CLK_DIV + 1;
`ifdef SINE_DAC_OFFSET_BIN_EN
  localparam logic [15:0] FLIP = 16'h8000;
`else
  localparam logic [15:0] FLIP = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, sclk, mosi, cs_n, busy, frame_done, overrun;

  sine_dac_spi dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          cyc = 0;
  int          last_start = -1000;
  bit          mfull = 1'b0;
  bit          movr = 1'b0;
  logic [15:0] mbuf = '0;
  logic [23:0] exp_q[$];
  logic [23:0] rx_q[$];

  // serial monitor state
  logic [23:0] cap = '0;
  int          cap_n = 0;
  int          sclk_rises = 0;
  bit          prev_sclk = 1'b0;
  bit          prev_cs = 1'b1;

  typedef struct {
    logic [31:0] data;
    int unsigned gap;
    bit          accept;
    logic [15:0] exp_data;
    bit          exp_ovr;
  } vec_t;
  localparam int NTBL = 8;
  vec_t tbl[NTBL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A frame starts on the first edge where a sample is buffered and the previous frame is over;
  // cs_n stays low for FRAME_CYC-1 edges and the next start is at least FRAME_CYC edges later.
  task automatic model_step(input bit v, input logic [31:0] d);
    bit idle, take;
    cyc++;
    if (!rst_n) begin
      mfull = 1'b0; movr = 1'b0; last_start = -1000; exp_q.delete();
      return;
    end
    idle = (cyc >= last_start + FRAME_CYC);
    take = mfull && idle;
    if (take) begin
      exp_q.push_back({CMD, mbuf});
      last_start = cyc;
    end
    if (v && (!mfull || take)) begin
      mbuf  = d[31:16] ^ FLIP;
      mfull = 1'b1;
    end else begin
      if (v) movr = 1'b1;
      if (take) mfull = 1'b0;
    end
  endtask

  task automatic check_cycle();
    bit eb, ed;
    eb = (cyc >= last_start) && (cyc < last_start + FRAME_CYC - 1);
    ed = (cyc == last_start + FRAME_CYC - 1);
    check("cycle_ctl", 32'({busy, cs_n, frame_done, in_ready, overrun, sclk & ~eb}),
          32'({eb, ~eb, ed, ~mfull, movr, 1'b0}));
    if (!rst_n) begin
      cap_n = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
    end else begin
      if (sclk && !prev_sclk) begin
        cap = {cap[22:0], mosi};
        cap_n++;
        sclk_rises++;
      end
      if (cs_n && !prev_cs) begin
        rx_q.push_back(cap);
        check("frame_bits", 32'(cap_n), 32'(NBITS));
        check("frame_queued", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) check("frame_data", 32'(cap), 32'(exp_q.pop_front()));
        cap_n = 0;
      end
      prev_sclk = sclk;
      prev_cs   = cs_n;
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mfull || busy) && n < 2000) begin
      cycle(1'b0, '0);
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 32'(1));
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_state(input string name);
    check(name, 32'({sclk, mosi, cs_n, busy, frame_done, overrun, in_ready}), 32'(7'b0010001));
  endtask

  initial begin
    int n, r0, n_acc;
    tbl[0] = '{32'h7FFF_0000, 260, 1'b1, 16'h7FFF, 1'b0};
    tbl[1] = '{32'h1234_5678,  50, 1'b1, 16'h1234, 1'b0};
    tbl[2] = '{32'hABCD_0000, 400, 1'b1, 16'hABCD, 1'b0};
    tbl[3] = '{32'h8000_0000, 260, 1'b1, 16'h8000, 1'b0};
    tbl[4] = '{32'h0000_0000, 260, 1'b1, 16'h0000, 1'b0};
    tbl[5] = '{32'hC0DE_0001,  10, 1'b1, 16'hC0DE, 1'b0};
    tbl[6] = '{32'h5555_0000,  10, 1'b1, 16'h5555, 1'b0};
    tbl[7] = '{32'hAAAA_0000,  10, 1'b0, 16'hAAAA, 1'b1};

    // power-on reset
    rst_n = 1'b0;
    cycle(1'b0, '0);
    check_reset_state("reset_state");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0);
    rst_n = 1'b1;
    cycle(1'b0, '0);

    // single sample: frame_done latency and sclk edge count
    r0 = sclk_rises;
    cycle(1'b1, 32'h7FFF_0000);
    n = 0;
    while (!frame_done && n < 400) begin cycle(1'b0, '0); n++; end
    check("done_latency", 32'(n), 32'(FRAME_CYC));
    check("sclk_rises", 32'(sclk_rises - r0), 32'(NBITS));
    drain();

    // back-to-back: second sample arrives mid-frame, cs_n high exactly one clk between frames
    cycle(1'b1, 32'h1234_5678);
    for (int i = 0; i < 49; i++) cycle(1'b0, '0);
    cycle(1'b1, 32'hABCD_0000);
    n = 0;
    while (!frame_done && n < 400) begin cycle(1'b0, '0); n++; end
    check("b2b_first_done", 32'(n < 400), 32'(1));
    n = 0;
    while (cs_n && n < 50) begin cycle(1'b0, '0); n++; end
    check("b2b_cs_gap", 32'(n), 32'(1));
    drain();
    check("b2b_overrun", 32'(overrun), 32'(0));

    // table-driven vectors
    rx_q.delete();
    n_acc = 0;
    for (int i = 0; i < NTBL; i++) begin
      cycle(1'b1, tbl[i].data);
      for (int unsigned k = 1; k < tbl[i].gap; k++) cycle(1'b0, '0);
      check("tbl_overrun", 32'(overrun), 32'(tbl[i].exp_ovr));
      if (tbl[i].accept) n_acc++;
    end
    drain();
    check("tbl_frame_count", 32'(rx_q.size()), 32'(n_acc));
    for (int i = 0; i < NTBL; i++) begin
      if (tbl[i].accept && rx_q.size() > 0)
        check("tbl_frame", 32'(rx_q.pop_front()), 32'({CMD, tbl[i].exp_data ^ FLIP}));
    end
    check("overrun_sticky", 32'(overrun), 32'(1));

    // reset in the middle of a frame
    cycle(1'b1, 32'h1357_2468);
    for (int i = 0; i < 60; i++) cycle(1'b0, '0);
    rst_n = 1'b0;
    cycle(1'b0, '0);
    check_reset_state("midframe_reset");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0);
    rst_n = 1'b1;
    r0 = sclk_rises;
    for (int i = 0; i < 300; i++) cycle(1'b0, '0);
    check("no_sclk_after_reset", 32'(sclk_rises - r0), 32'(0));

    // random strobes against the model
    for (int s = 0; s < 40; s++) begin
      int unsigned gap;
      gap = $urandom_range(260, 1);
      cycle(1'b1, $urandom);
      for (int unsigned k = 1; k < gap; k++) cycle(1'b0, '0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no end of test, expected finish before 5 ms");
    $fatal(1, "timeout");
  end

endmodule
